// File: rtl/bcd_result_fmt_pkg.sv
// Shared types and constants for the BCD result formatter (package bcd_pkg).
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_COMP = 2'b10;
   localparam logic [1:0] OP_CMP  = 2'b11;

   localparam logic [15:0] BCD_ERR = 16'hCCCC;
   localparam logic [15:0] CMP_GT  = 16'h0001;
   localparam logic [15:0] CMP_LT  = 16'hFFFF;
   localparam logic [15:0] CMP_EQ  = 16'h0000;

endpackage

// File: rtl/bcd_result_fmt_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bcd_result_fmt.sv
// Binary-to-packed-BCD result formatter with sign/overflow/error flags.
// Optional macro BCD_FMT_SAT_EN: saturate out_bcd to all nines on overflow.
module bcd_result_fmt
   import bcd_pkg::*;
#(
   parameter int unsigned BITS_PER_CYC = 1,
   parameter int unsigned DIGITS       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [15:0]           in_c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIGITS*4-1:0]   out_bcd,
   output logic                  out_neg,
   output logic                  out_ovf,
   output logic                  out_err
);

   localparam int unsigned MAG_W = 16;
   localparam int unsigned SW    = (DIGITS + 1) * 4;
   localparam int unsigned OW    = DIGITS * 4;
   localparam int unsigned NCYC  = MAG_W / BITS_PER_CYC;
   localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SW-1:0]         scr_q, scr_d;
   logic [MAG_W-1:0]      mag_q, mag_d;
   logic                  neg_q, neg_d;
   logic                  err_q, err_d;
   logic                  out_valid_q, out_valid_d;
   logic [OW-1:0]         out_bcd_q, out_bcd_d;
   logic                  out_neg_q, out_neg_d;
   logic                  out_ovf_q, out_ovf_d;
   logic                  out_err_q, out_err_d;

   logic [SW-1:0]         scr_conv;
   logic [MAG_W-1:0]      mag_conv;
   logic                  ovf;

   // One combinational double-dabble step per consumed input bit.
   for (genvar b = 0; b < BITS_PER_CYC; b++) begin : g_step
      logic [SW-1:0]         scr_in, scr_adj, scr_out;
      logic [MAG_W-1:0]      mag_in, mag_out;
      logic [SW+MAG_W-1:0]   cat;

      if (b == 0) begin : g_first
         assign scr_in = scr_q;
         assign mag_in = mag_q;
      end else begin : g_chain
         assign scr_in = g_step[b-1].scr_out;
         assign mag_in = g_step[b-1].mag_out;
      end

      for (genvar d = 0; d < DIGITS + 1; d++) begin : g_dig
         bcd_add3_digit u_add3 (
            .digit_i (scr_in[d*4 +: 4]),
            .digit_o (scr_adj[d*4 +: 4])
         );
      end

      assign cat     = {scr_adj, mag_in} << 1;
      assign scr_out = cat[SW+MAG_W-1:MAG_W];
      assign mag_out = cat[MAG_W-1:0];
   end

   assign scr_conv = g_step[BITS_PER_CYC-1].scr_out;
   assign mag_conv = g_step[BITS_PER_CYC-1].mag_out;
   assign ovf      = (scr_q[SW-1:SW-4] != 4'h0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      scr_d       = scr_q;
      mag_d       = mag_q;
      neg_d       = neg_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_bcd_d   = out_bcd_q;
      out_neg_d   = out_neg_q;
      out_ovf_d   = out_ovf_q;
      out_err_d   = out_err_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cnt_d = '0;
               if (in_c == BCD_ERR) begin
                  scr_d   = SW'(BCD_ERR);
                  neg_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (in_op == OP_CMP) begin
                  // Compare results reuse the scratch so DONE entry is uniform.
                  neg_d   = 1'b0;
                  err_d   = 1'b0;
                  state_d = DONE;
                  if (in_c == CMP_EQ) begin
                     scr_d = '0;
                  end else if (in_c == CMP_GT) begin
                     scr_d = SW'(16'h0001);
                  end else if (in_c == CMP_LT) begin
                     scr_d = SW'(16'h0001);
                     neg_d = 1'b1;
                  end else begin
                     scr_d = SW'(BCD_ERR);
                     err_d = 1'b1;
                  end
               end else begin
                  scr_d   = '0;
                  err_d   = 1'b0;
                  state_d = CONV;
                  if ((in_op == OP_SUB) && in_c[15]) begin
                     neg_d = 1'b1;
                     mag_d = (~in_c) + 16'd1;
                  end else begin
                     neg_d = 1'b0;
                     mag_d = in_c;
                  end
               end
            end
         end

         CONV: begin
            scr_d = scr_conv;
            mag_d = mag_conv;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NCYC - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_ovf_d   = ovf;
               out_neg_d   = neg_q;
               out_err_d   = err_q;
`ifdef BCD_FMT_SAT_EN
               out_bcd_d   = ovf ? {DIGITS{4'h9}} : scr_q[OW-1:0];
`else
               out_bcd_d   = scr_q[OW-1:0];
`endif
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         scr_q       <= '0;
         mag_q       <= '0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_bcd_q   <= '0;
         out_neg_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         scr_q       <= scr_d;
         mag_q       <= mag_d;
         neg_q       <= neg_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_bcd_q   <= out_bcd_d;
         out_neg_q   <= out_neg_d;
         out_ovf_q   <= out_ovf_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_bcd   = out_bcd_q;
   assign out_neg   = out_neg_q;
   assign out_ovf   = out_ovf_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_result_fmt.sv
// Directed self-checking bench for bcd_result_fmt (default parameters).
module tb_bcd_result_fmt;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [15:0] in_c;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic        out_neg;
   logic        out_ovf;
   logic        out_err;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   bcd_result_fmt #(.BITS_PER_CYC(1), .DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_neg   (out_neg),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

`ifdef BCD_FMT_SAT_EN
   localparam logic [15:0] EXP_12345 = 16'h9999;
   localparam logic [15:0] EXP_19998 = 16'h9999;
`else
   localparam logic [15:0] EXP_12345 = 16'h2345;
   localparam logic [15:0] EXP_19998 = 16'h9998;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one operation at posedge+1 and hold until accepted.
   task automatic send(input string tag, input logic [1:0] op, input logic [15:0] c);
      int unsigned n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_c     = c;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_c     = 16'h0000;
   endtask

   task automatic wait_out(input string tag, input int unsigned exp_lat);
      int unsigned lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 60);
      check({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic check_out(input string tag, input logic [15:0] bcd,
                            input logic neg, input logic ovf, input logic err);
      check({tag, "_bcd"}, {16'd0, out_bcd}, {16'd0, bcd});
      check({tag, "_neg"}, {31'd0, out_neg}, {31'd0, neg});
      check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
      check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_rise"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] c,
                         input int unsigned lat, input logic [15:0] bcd,
                         input logic neg, input logic ovf, input logic err);
      send(tag, op, c);
      wait_out(tag, lat);
      check_out(tag, bcd, neg, ovf, err);
      drain(tag);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_c      = 16'h0000;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      run_op("add_12345", 2'b00, 16'd12345, 17, EXP_12345, 1'b0, 1'b1, 1'b0);
      run_op("sub_neg10", 2'b01, 16'hFFF6,  17, 16'h0010,  1'b1, 1'b0, 1'b0);
      run_op("sub_pos500", 2'b01, 16'd500,  17, 16'h0500,  1'b0, 1'b0, 1'b0);
      run_op("comp_9999", 2'b10, 16'd9999,  17, 16'h9999,  1'b0, 1'b0, 1'b0);
      run_op("add_zero",  2'b00, 16'd0,     17, 16'h0000,  1'b0, 1'b0, 1'b0);
      run_op("add_19998", 2'b00, 16'd19998, 17, EXP_19998, 1'b0, 1'b1, 1'b0);
      run_op("cmp_lt",    2'b11, 16'hFFFF,  1,  16'h0001,  1'b1, 1'b0, 1'b0);
      run_op("cmp_gt",    2'b11, 16'h0001,  1,  16'h0001,  1'b0, 1'b0, 1'b0);
      run_op("cmp_eq",    2'b11, 16'h0000,  1,  16'h0000,  1'b0, 1'b0, 1'b0);
      run_op("cmp_bad",   2'b11, 16'h0005,  1,  16'hCCCC,  1'b0, 1'b0, 1'b1);
      run_op("err_add",   2'b00, 16'hCCCC,  1,  16'hCCCC,  1'b0, 1'b0, 1'b1);
      run_op("err_sub",   2'b01, 16'hCCCC,  1,  16'hCCCC,  1'b0, 1'b0, 1'b1);

      // Back-pressure with a competing in_valid that must be ignored.
      send("bp", 2'b00, 16'd4321);
      wait_out("bp", 17);
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_c     = 16'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_bcd", {16'd0, out_bcd}, 32'h4321);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_out("bp_final", 16'h4321, 1'b0, 1'b0, 1'b0);
      drain("bp");
      @(posedge clk); #1;
      check("bp_no_stray_valid", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a conversion discards it.
      send("abort", 2'b00, 16'd1234);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check_out("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      run_op("after_abort", 2'b00, 16'd42, 17, 16'h0042, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
